// File: rtl/inst_buffer.sv
// Instruction buffer between I-cache fetch and decode: circular queue of DEPTH decoded-slot entries.
// Optional same-cycle bypass of the first fetched word when empty: define IB_BYPASS_EN.
module inst_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTAB_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       icache_ns,
  output logic                       ib_allin,
  input  logic [127:0]               icache_ib_data,
  input  logic [31:0]                icache_ib_pc,
  input  logic [PTAB_W-1:0]          icache_ib_ptab,
  input  logic [31:0]                icache_ib_branch_pc,
  input  logic                       icache_ib_delot_en,
  output logic                       id_valid,
  input  logic                       id_allin,
  output logic [31:0]                id_inst,
  output logic [31:0]                id_pc,
  output logic [PTAB_W-1:0]          id_ptab,
  output logic [31:0]                id_branch_pc,
  output logic                       id_delot,
  output logic [$clog2(DEPTH):0]     ib_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]       inst;
    logic [31:0]       pc;
    logic [PTAB_W-1:0] ptab;
    logic [31:0]       branch_pc;
    logic              delot;
  } ib_entry_t;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ib_entry_t        mem_q [DEPTH];
  ib_entry_t        mem_d [DEPTH];
  ib_entry_t        grp   [4];
  ib_entry_t        head;
  logic [1:0]       start_off;
  logic [2:0]       n_grp;
  logic [2:0]       n_store;
  logic             wr_en;
  logic             rd_en;
  logic             byp_valid;
  logic             byp_take;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^icache_ib_pc[1:0];

  assign start_off = icache_ib_pc[3:2];
  assign n_grp     = 3'd4 - {1'b0, start_off};
  assign ib_allin  = (count_q <= CNT_W'(DEPTH - 4));
  assign wr_en     = icache_ns && ib_allin && !flush;
  assign rd_en     = (count_q != '0) && id_allin && !flush;
  assign ib_count  = count_q;

`ifdef IB_BYPASS_EN
  assign byp_valid = wr_en && (count_q == '0);
`else
  assign byp_valid = 1'b0;
`endif
  assign byp_take  = byp_valid && id_allin;
  assign n_store   = n_grp - 3'(byp_take);

  // Expand the fetch group into per-word entries indexed by line offset.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp[k].inst      = icache_ib_data[32*k +: 32];
      grp[k].pc        = {icache_ib_pc[31:4], 2'(k), 2'b00};
      grp[k].ptab      = icache_ib_ptab;
      grp[k].branch_pc = icache_ib_branch_pc;
      grp[k].delot     = icache_ib_delot_en && (2'(k) == start_off);
    end
  end

  // Store the wanted words (minus a bypassed head word) contiguously from wr_ptr.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < n_store) begin
          mem_d[wr_ptr_q + PTR_W'(j)] = grp[start_off + 2'(j) + 2'(byp_take)];
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(n_store);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en ? n_store : 3'd0) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    id_valid     = 1'b0;
    id_inst      = '0;
    id_pc        = '0;
    id_ptab      = '0;
    id_branch_pc = '0;
    id_delot     = 1'b0;
    if (count_q != '0) begin
      id_valid     = 1'b1;
      id_inst      = head.inst;
      id_pc        = head.pc;
      id_ptab      = head.ptab;
      id_branch_pc = head.branch_pc;
      id_delot     = head.delot;
    end
    if (byp_valid) begin
      id_valid     = 1'b1;
      id_inst      = grp[start_off].inst;
      id_pc        = grp[start_off].pc;
      id_ptab      = grp[start_off].ptab;
      id_branch_pc = grp[start_off].branch_pc;
      id_delot     = grp[start_off].delot;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model plus directed literal checks.
module tb_inst_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTAB_W = 3;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               icache_ns;
  logic               ib_allin;
  logic [127:0]       icache_ib_data;
  logic [31:0]        icache_ib_pc;
  logic [PTAB_W-1:0]  icache_ib_ptab;
  logic [31:0]        icache_ib_branch_pc;
  logic               icache_ib_delot_en;
  logic               id_valid;
  logic               id_allin;
  logic [31:0]        id_inst;
  logic [31:0]        id_pc;
  logic [PTAB_W-1:0]  id_ptab;
  logic [31:0]        id_branch_pc;
  logic               id_delot;
  logic [CNT_W-1:0]   ib_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]       inst;
    logic [31:0]       pc;
    logic [PTAB_W-1:0] ptab;
    logic [31:0]       bpc;
    logic              delot;
  } ent_t;

  ent_t q[$];

  inst_buffer #(.DEPTH(DEPTH), .PTAB_W(PTAB_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .icache_ns(icache_ns), .ib_allin(ib_allin),
    .icache_ib_data(icache_ib_data), .icache_ib_pc(icache_ib_pc), .icache_ib_ptab(icache_ib_ptab),
    .icache_ib_branch_pc(icache_ib_branch_pc), .icache_ib_delot_en(icache_ib_delot_en),
    .id_valid(id_valid), .id_allin(id_allin), .id_inst(id_inst), .id_pc(id_pc), .id_ptab(id_ptab),
    .id_branch_pc(id_branch_pc), .id_delot(id_delot), .ib_count(ib_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int k);
    ent_t e;
    e.inst  = icache_ib_data[32*k +: 32];
    e.pc    = {icache_ib_pc[31:4], 2'(k), 2'b00};
    e.ptab  = icache_ib_ptab;
    e.bpc   = icache_ib_branch_pc;
    e.delot = icache_ib_delot_en && (k == int'(icache_ib_pc[3:2]));
    return e;
  endfunction

  function automatic logic byp_now();
`ifdef IB_BYPASS_EN
    return (q.size() == 0) && icache_ns && !flush && reset;
`else
    return 1'b0;
`endif
  endfunction

  // Compare all DUT outputs with what the model says is visible right now.
  task automatic check_outputs();
    ent_t eh;
    logic ev;
    int   sz;
    sz = q.size();
    eh = '0;
    ev = (sz != 0);
    if (ev) eh = q[0];
    if (byp_now()) begin
      ev = 1'b1;
      eh = mk(int'(icache_ib_pc[3:2]));
    end
    chk("id_valid", 32'(id_valid), 32'(ev));
    chk("ib_allin", 32'(ib_allin), 32'((int'(DEPTH) - sz) >= 4));
    chk("ib_count", 32'(ib_count), 32'(sz));
    chk("id_inst", id_inst, eh.inst);
    chk("id_pc", id_pc, eh.pc);
    chk("id_ptab", 32'(id_ptab), 32'(eh.ptab));
    chk("id_branch_pc", id_branch_pc, eh.bpc);
    chk("id_delot", 32'(id_delot), 32'(eh.delot));
  endtask

  task automatic model_update();
    int  sz;
    bit  wr, rd, skip;
    if (!reset || flush) begin
      q.delete();
      return;
    end
    sz   = q.size();
    wr   = icache_ns && ((int'(DEPTH) - sz) >= 4);
    rd   = (sz != 0) && id_allin;
    skip = byp_now() && id_allin;
    if (rd) void'(q.pop_front());
    if (wr)
      for (int k = int'(icache_ib_pc[3:2]) + int'(skip); k < 4; k++) q.push_back(mk(k));
  endtask

  // Inputs are set just after a falling edge; check, advance the model, cross one rising edge.
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_group(input logic [31:0] pc, input logic [31:0] base,
                           input logic [PTAB_W-1:0] ptab, input logic [31:0] bpc, input logic dl);
    icache_ib_pc        = pc;
    icache_ib_ptab      = ptab;
    icache_ib_branch_pc = bpc;
    icache_ib_delot_en  = dl;
    for (int k = 0; k < 4; k++) icache_ib_data[32*k +: 32] = base + 32'(k);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; icache_ns = 1'b0; id_allin = 1'b0;
    set_group(32'h0, 32'h0, '0, 32'h0, 1'b0);
    @(negedge clk);

    // 1: reset then idle
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_ib_allin", 32'(ib_allin), 32'd1);
    chk("rst_ib_count", 32'(ib_count), 32'd0);
    step(); step();
    reset = 1'b1;
    step(); step();
    #1;
    chk("idle_ib_count", 32'(ib_count), 32'd0);
    chk("idle_id_valid", 32'(id_valid), 32'd0);

    // 2: aligned group streams out in order
    id_allin = 1'b1;
    set_group(32'h0000_1000, 32'hA000_0000, 3'd5, 32'h0000_4000, 1'b0);
    icache_ns = 1'b1;
    step();
    icache_ns = 1'b0;
`ifndef IB_BYPASS_EN
    #1;
    chk("aligned_first_inst", id_inst, 32'hA000_0000);
    chk("aligned_first_pc", id_pc, 32'h0000_1000);
`endif
    repeat (5) step();

    // 3: unaligned group with delay slot
    id_allin = 1'b0;
    set_group(32'h0000_1008, 32'hA000_0000, 3'd2, 32'h0000_5000, 1'b1);
    icache_ns = 1'b1;
    step();
    icache_ns = 1'b0;
    #1;
    chk("unal_count", 32'(ib_count), 32'd2);
    chk("unal_inst", id_inst, 32'hA000_0002);
    chk("unal_pc", id_pc, 32'h0000_1008);
    chk("unal_delot", 32'(id_delot), 32'd1);
    step();
    id_allin = 1'b1;
    repeat (4) step();

    // 4: fill to full, hold a fifth group, then drain across the wrap
    id_allin = 1'b0;
    icache_ns = 1'b1;
    for (int g = 0; g < 4; g++) begin
      set_group(32'h0000_2000 + 32'(16*g), 32'hB000_0000 + 32'(g << 8), 3'(g), 32'h0000_6000, 1'b0);
      step();
    end
    set_group(32'h0000_2040, 32'hB000_0400, 3'd4, 32'h0000_6000, 1'b0);
    #1;
    chk("full_count", 32'(ib_count), 32'd16);
    chk("full_allin", 32'(ib_allin), 32'd0);
    step(); step();
    id_allin = 1'b1;
    repeat (4) step();
    #1;
    chk("drain4_allin", 32'(ib_allin), 32'd1);
    step();
    icache_ns = 1'b0;
    repeat (18) step();

    // count==1 with simultaneous write and read
    id_allin = 1'b0;
    set_group(32'h0000_300C, 32'hC000_0000, 3'd1, 32'h0000_7000, 1'b0);
    icache_ns = 1'b1;
    step();
    set_group(32'h0000_3010, 32'hC100_0000, 3'd1, 32'h0000_7000, 1'b0);
    id_allin = 1'b1;
    step();
    icache_ns = 1'b0;
    repeat (6) step();

    // 5: flush beats a simultaneous write and read at count 6
    id_allin = 1'b0;
    icache_ns = 1'b1;
    set_group(32'h0000_4000, 32'hD000_0000, 3'd3, 32'h0000_8000, 1'b0);
    step();
    set_group(32'h0000_4018, 32'hD100_0000, 3'd3, 32'h0000_8000, 1'b0);
    step();
    #1;
    chk("preflush_count", 32'(ib_count), 32'd6);
    set_group(32'h0000_4020, 32'hEEEE_0000, 3'd7, 32'h0000_9000, 1'b0);
    id_allin = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    icache_ns = 1'b0;
    #1;
    chk("flush_count", 32'(ib_count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_allin", 32'(ib_allin), 32'd1);
    repeat (3) step();

    // 6: start offset 1 into an empty buffer
    set_group(32'h0000_2004, 32'hF000_0000, 3'd6, 32'h0000_A000, 1'b0);
    icache_ns = 1'b1;
    #1;
`ifdef IB_BYPASS_EN
    chk("byp_same_cycle_inst", id_inst, 32'hF000_0001);
`else
    chk("nobyp_same_cycle_valid", 32'(id_valid), 32'd0);
`endif
    step();
    icache_ns = 1'b0;
    #1;
`ifdef IB_BYPASS_EN
    chk("byp_next_count", 32'(ib_count), 32'd2);
`else
    chk("nobyp_next_count", 32'(ib_count), 32'd3);
    chk("nobyp_next_inst", id_inst, 32'hF000_0001);
`endif
    repeat (4) step();

    // Reset in the middle of traffic clears at once
    id_allin = 1'b0;
    set_group(32'h0000_5000, 32'h1234_0000, 3'd1, 32'h0000_B000, 1'b0);
    icache_ns = 1'b1;
    step();
    icache_ns = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_count", 32'(ib_count), 32'd0);
    chk("midrst_valid", 32'(id_valid), 32'd0);
    q.delete();
    step();
    reset = 1'b1;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
